// File: rtl/demux_scan_pkg.sv
// Shared definitions for the demux scan driver: FSM state encoding and
// default geometry of the 1-to-8 demultiplexer it feeds.
package demux_scan_pkg;

    localparam int DEMUX_SEL_W = 3;
    localparam int DEMUX_SLOTS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GUARD = 2'd2
    } scan_state_e;

endpackage

// File: rtl/demux_scan_driver.sv
// Scan driver for a combinational 1-to-N demultiplexer.
// Accepts one parallel word per valid/ready handshake, then steps `sel`
// through slots 0..SLOTS-1 in ascending order, presenting word bit k on
// `in` while `sel` == k, each slot lasting HOLD clock cycles (HOLD: 1..255).
// Optional feature macro: DEMUX_SCAN_GUARD_EN -- when defined, a one-cycle
// GUARD gap with in=0 is inserted before every slot change so that `sel`
// never moves while `in` is high.
module demux_scan_driver
    import demux_scan_pkg::*;
#(
    parameter int SEL_W = DEMUX_SEL_W,
    parameter int HOLD  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    word_valid,
    output logic                    word_ready,
    input  logic [(1<<SEL_W)-1:0]   word_data,
    output logic                    in,
    output logic [SEL_W-1:0]        sel,
    output logic                    busy,
    output logic                    done
);

    localparam int SLOTS = 1 << SEL_W;
    localparam int HW    = $clog2(HOLD + 1);

    localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(SLOTS - 1);
    localparam logic [SEL_W-1:0] IDX_STEP  = SEL_W'(1);
    localparam logic [HW-1:0]    HOLD_ONE  = HW'(1);
    localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD);

    scan_state_e         state_q;
    logic [SEL_W-1:0]    idx_q;
    logic [HW-1:0]       hold_q;     // cycles the current slot has been driven (1..HOLD)
    logic [SLOTS-1:0]    word_q;     // captured word; upstream data is not used after accept
    logic                in_q;
    logic [SEL_W-1:0]    sel_q;
    logic                busy_q;
    logic                done_q;
    logic                ready_q;

    logic [SEL_W-1:0]    idx_d;

    // Index of the next slot; a scan ends at LAST_IDX so this never wraps mid-word.
    assign idx_d = idx_q + IDX_STEP;

    // Scan FSM with hold and index counters; every output is a register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
            word_q  <= '0;
            in_q    <= 1'b0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    in_q    <= 1'b0;
                    sel_q   <= '0;
                    // ready_q is the registered output, so the first edge
                    // after reset release can never accept a word.
                    if (word_valid && ready_q) begin
                        word_q  <= word_data;
                        state_q <= DRIVE;
                        idx_q   <= '0;
                        hold_q  <= HOLD_ONE;
                        sel_q   <= '0;
                        in_q    <= word_data[0];
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end

                DRIVE: begin
                    if (hold_q != HOLD_LAST) begin
                        hold_q <= hold_q + HOLD_ONE;
                    end else if (idx_q == LAST_IDX) begin
                        // Last slot finished: one-cycle done pulse, ready again.
                        state_q <= IDLE;
                        idx_q   <= '0;
                        hold_q  <= '0;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        in_q    <= 1'b0;
                        sel_q   <= '0;
                    end else begin
`ifdef DEMUX_SCAN_GUARD_EN
                        // Move sel while in is forced low; the bit follows next cycle.
                        state_q <= GUARD;
                        idx_q   <= idx_d;
                        sel_q   <= idx_d;
                        in_q    <= 1'b0;
`else
                        // Contiguous slots: sel and in change on the same edge.
                        idx_q   <= idx_d;
                        sel_q   <= idx_d;
                        in_q    <= word_q[idx_d];
                        hold_q  <= HOLD_ONE;
`endif
                    end
                end

`ifdef DEMUX_SCAN_GUARD_EN
                GUARD: begin
                    state_q <= DRIVE;
                    hold_q  <= HOLD_ONE;
                    in_q    <= word_q[idx_q];
                end
`endif

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign word_ready = ready_q;
    assign in         = in_q;
    assign sel        = sel_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_demux_scan_driver.sv
// Self-checking bench for demux_scan_driver. Expected per-cycle outputs
// {in, sel, busy, done, word_ready} are queued when a word is accepted and
// compared each cycle; with an empty queue the driver must be idle.
// Honors DEMUX_SCAN_GUARD_EN for the expected slot timing.
module tb_demux_scan_driver;

    localparam int SEL_W = 3;
    localparam int SLOTS = 8;
    localparam int HOLD  = 2;

    localparam logic [6:0] IDLE_V = 7'b0_000_0_0_1;
    localparam logic [6:0] ZERO_V = 7'b0_000_0_0_0;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             word_valid = 1'b0;
    logic [SLOTS-1:0] word_data = '0;
    logic             word_ready;
    logic             dut_in;
    logic [SEL_W-1:0] dut_sel;
    logic             dut_busy;
    logic             dut_done;

    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    logic [6:0] exp_q[$];

    demux_scan_driver #(
        .SEL_W (SEL_W),
        .HOLD  (HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_data  (word_data),
        .in         (dut_in),
        .sel        (dut_sel),
        .busy       (dut_busy),
        .done       (dut_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {dut_in, dut_sel, dut_busy, dut_done, word_ready};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected cycle-by-cycle outputs for one accepted word, plus its done cycle.
    task automatic push_word(input logic [SLOTS-1:0] w);
        for (int k = 0; k < SLOTS; k++) begin
            for (int h = 0; h < HOLD; h++)
                exp_q.push_back({w[k], 3'(k), 1'b1, 1'b0, 1'b0});
`ifdef DEMUX_SCAN_GUARD_EN
            if (k < SLOTS - 1)
                exp_q.push_back({1'b0, 3'(k + 1), 1'b1, 1'b0, 1'b0});
`endif
        end
        exp_q.push_back({1'b0, 3'd0, 1'b0, 1'b1, 1'b1});
    endtask

    // Offer a word and hold it until the handshake edge; leaves word_valid high.
    task automatic send(input logic [SLOTS-1:0] w);
        int n;
        n = 0;
        @(negedge clk);
        word_valid = 1'b1;
        word_data  = w;
        while (!word_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!word_ready) begin
            check("send_timeout", 32'd0, 32'd1);
            word_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        push_word(w);
        $display("word %02h accepted at %0t", w, $time);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0)
            check("drain_timeout", exp_q.size(), 0);
    endtask

    // Per-cycle monitor: scheduled scan outputs, or idle when nothing is queued.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                logic [6:0] e;
                e = exp_q.pop_front();
                check("scan", outs(), e);
            end else begin
                check("idle", outs(), IDLE_V);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and ready rising one edge after release.
        #3 check("rst_outs", outs(), ZERO_V);
        @(negedge clk);
        rst = 1'b0;
        #1 check("rel_ready0", outs(), ZERO_V);
        @(negedge clk);
        #1 check("rel_ready1", outs(), IDLE_V);
        mon_en = 1'b1;

        // Single bit.
        send(8'h04);
        word_valid = 1'b0;
        drain();

        // Full word.
        send(8'hFF);
        word_valid = 1'b0;
        drain();

        // Back-to-back with word_valid held: second accept in the done cycle.
        send(8'hA5);
        send(8'h5A);
        word_valid = 1'b0;
        drain();

        // Backpressure: next word offered throughout the current scan.
        send(8'h3C);
        send(8'h81);
        word_valid = 1'b0;
        drain();

        // Random words with random idle gaps.
        for (int i = 0; i < 4; i++) begin
            send(8'($urandom));
            word_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            drain();
        end

        // Reset mid-scan: immediate zero outputs, no done, ready after release.
        send(8'hF0);
        word_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst    = 1'b1;
        mon_en = 1'b0;
        exp_q.delete();
        #1 check("rst_mid", outs(), ZERO_V);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_hold", outs(), ZERO_V);
        end
        rst = 1'b0;
        #1 check("rst_rel0", outs(), ZERO_V);
        @(negedge clk);
        #1 check("rst_rel1", outs(), IDLE_V);
        mon_en = 1'b1;
        repeat (4) @(negedge clk);

        // Scan resumes normally after the abort.
        send(8'h01);
        word_valid = 1'b0;
        drain();
        repeat (2) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_scan_driver.md
# demux_scan_driver

Sequential driver that sits directly upstream of the 1-to-8 `Demultiplexer` and generates its `in` and `s0`/`s1`/`s2` stimulus. It accepts one parallel word per valid/ready handshake. It then walks the select lines through every slot index in ascending order, presenting the matching word bit on `in`, so that bit *k* appears on demux output `d`*k*. Its job is to turn an 8-bit parallel word into a timed, glitch-controlled slot sequence for the combinational demux.

## Interface
- `SEL_W`, default 3: select width. `SLOTS = 1 << SEL_W` (8 by default, one slot per `d0`..`d7`).
- `HOLD`, default 1: clock cycles each slot is driven. Legal range is 1..255.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, **asynchronous, active-high**. This is already decided.
- `word_valid`  in  1  upstream word available.
- `word_ready`  out  1  driver can accept a word.
- `word_data`  in  SLOTS  bit *k* is routed to slot *k*.
- `in`  out  1  data to demux `in`.
- `sel`  out  SEL_W  slot index. `s0=sel[0]`, `s1=sel[1]`, `s2=sel[2]`.
- `busy`  out  1  a word is being scanned.
- `done`  out  1  one-cycle pulse when a word's scan completes.

## Operation
- All outputs are registered.
- **Reset values while `rst` is high:** `in=0`, `sel=0`, `busy=0`, `done=0`, `word_ready=0`, state `IDLE`, counters 0.
- `word_ready` rises on the first clock edge after `rst` deasserts.
- **Handshake:** a word is accepted at a rising edge where `word_valid && word_ready`. `word_data` is captured into an internal shift/hold register. Upstream data is not used after acceptance.
- `word_valid` held with `word_ready=0` is not an acceptance. Upstream must hold the word until the handshake completes.
- **`IDLE`:** `word_ready=1`, `in=0`, `sel=0`, `busy=0`. On accept, go to `DRIVE` with slot index 0.
- **`DRIVE`:** `sel` = current index, `in` = captured bit[index], `busy=1`, `word_ready=0`.
  - Stay for `HOLD` cycles, counted by the hold counter, width `$clog2(HOLD+1)`.
  - If index ≠ `SLOTS-1`: go to `GUARD` if the macro is defined, otherwise stay in `DRIVE` with index+1.
  - If index = `SLOTS-1`: go to `IDLE` and pulse `done`.
- **`GUARD`** (macro builds only): one cycle with `in=0` and `sel` already at index+1. Then go to `DRIVE`.
- The index counter is SEL_W bits. It never wraps mid-word, because a scan ends at `SLOTS-1`.
- A bit value of 0 still occupies its slot, with `in=0` and `sel` stepping normally.
- Reset mid-scan aborts immediately to the reset values. The partially scanned word is discarded and `done` is not asserted.

## Timing
- Word accepted at edge E → slot 0 is on the outputs from E+1.
- Without guard: slot *k* occupies cycles E+1+k·HOLD .. E+(k+1)·HOLD.
  - Total scan length is SLOTS·HOLD cycles.
- With guard: slot *k* starts at E+1+k·(HOLD+1).
  - Total scan length is SLOTS·HOLD + SLOTS − 1 cycles.
- In the cycle after the last slot: `done=1`, `word_ready=1`, `busy=0`, `in=0`, `sel=0`.
- Back-to-back words: the next accept can occur at the edge ending that cycle. This gives exactly one idle cycle between consecutive scans.
- `sel` and `in` change on the same edge. Without guard, the demux may glitch at slot boundaries where adjacent bits are both 1.

## Configuration
- Macro: `DEMUX_SCAN_GUARD_EN`.
- **Defined:** the `GUARD` state is compiled in. `in` is 0 whenever `sel` changes, so each demux output sees a clean pulse.
- **Undefined:** there is no `GUARD` state. Slots are contiguous and the scan is fastest.

## Structure
- Shared package `demux_scan_pkg` holds:
  - the state enum (`IDLE`, `DRIVE`, `GUARD`);
  - default constants `DEMUX_SEL_W = 3` and `DEMUX_SLOTS = 8`.
- No sub-module is needed. It is a single FSM plus the hold counter and index counter.
- Top-level system wiring instantiates `demux_scan_driver` next to `Demultiplexer`, connecting `sel[0..2]` to `s0..s2`.

## Test plan
- **Reset:** assert `rst` mid-scan → all outputs go to 0 at once. `word_ready` returns to 1 one cycle after release, and `done` never pulses.
- **Single bit:** defaults, `word_data=8'h04` → `in=1` only while `sel=2` (demux `d2` high for 1 cycle). `done` pulses 9 cycles after accept.
- **Full word:** `word_data=8'hFF`, `HOLD=3` → each `sel` 0..7 is held 3 cycles with `in=1`. 24 scan cycles, then `done`.
- **Guard build:** `DEMUX_SCAN_GUARD_EN`, `word_data=8'hFF`, `HOLD=1` → `in` toggles 1,0,1,0…, ending 1. `sel` steps during the `in=0` cycles. Scan length is 15 cycles.
- **Back-to-back:** `word_valid` held high with words `8'hA5` then `8'h5A` → second accept occurs in the `done` cycle. Slot 0 of the second word follows one cycle later.
- **Backpressure:** `word_valid` asserted while `busy` → no capture, `word_ready` stays 0, and the current scan is unaffected.
